mem_port_arbiter: RTL and testbench

Arbitrates the CPU's two memory ports onto one shared physical-memory port. Port A carries instruction fetches (read-only); port B carries data loads and stores. The block sits directly downstream of the CPU top level and upstream of the unified cache/memory controller. It serialises requests, holds exactly one transaction in flight, and routes each response back to the port that issued it.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch A, data load/store B) to single physical-memory port arbiter.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; default is fixed priority to B.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // port A: instruction fetch, read-only
  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,
  // port B: data loads and stores
  input  logic                read_b,
  input  logic                write,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,
  // shared physical-memory port
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_wmask,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_reg;

  logic req_a;
  logic req_b;
  logic grant_b;

  assign req_a = read_a;
  assign req_b = read_b | write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = port B was granted most recently; reset favours B on the first tie
  logic last_b_reg;

  assign grant_b = req_b & (~req_a | ~last_b_reg);
`else
  assign grant_b = req_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      resp_a       <= 1'b0;
      resp_b       <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_b_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          resp_a <= 1'b0;
          resp_b <= 1'b0;
          if (grant_b) begin
            // read_b together with write is treated as a write
            state_reg    <= SERVE_B;
            pmem_write   <= write;
            pmem_read    <= ~write;
            pmem_address <= address_b;
            pmem_wdata   <= wdata;
            pmem_wmask   <= wmask;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_b_reg   <= 1'b1;
`endif
          end else if (req_a) begin
            state_reg    <= SERVE_A;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= address_a;
            pmem_wdata   <= '0;
            pmem_wmask   <= {MASK_W{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_b_reg   <= 1'b0;
`endif
          end
        end

        SERVE_A: begin
          if (pmem_resp) begin
            state_reg  <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            rdata_a    <= pmem_rdata;
            resp_a     <= 1'b1;
          end
        end

        SERVE_B: begin
          if (pmem_resp) begin
            state_reg  <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            // stores leave the last load data visible on rdata_b
            if (!pmem_write) begin
              rdata_b <= pmem_rdata;
            end
            resp_b     <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          resp_a    <= 1'b0;
          resp_b    <= 1'b0;
        end

        default: begin
          state_reg  <= IDLE;
          resp_a     <= 1'b0;
          resp_b     <= 1'b0;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and responses are queued when driven,
// a downstream memory model checks each grant and answers it, the main flow checks each resp.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_a = 1'b0;
  logic [31:0] address_a = '0;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] address_b = '0;
  logic [31:0] wdata = '0;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b), .wdata(wdata),
    .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port_b;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wm;
    int          lat;
    logic [31:0] rd;
    int          gap;
  } gnt_t;

  typedef struct {
    bit          port_b;
    logic [31:0] rd;
  } rsp_t;

  gnt_t q_gnt[$];
  rsp_t q_rsp[$];

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_resp_cyc = 0;
  int          spur_req = 0;
  int          spur_ack = 0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic [31:0] mdl_a = '0;
  logic [31:0] mdl_b = '0;
  bit          last_b_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_txn(input bit pb, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] wm, input int lat, input logic [31:0] rd, input int gap);
    gnt_t g;
    rsp_t r;
    g.port_b = pb;
    g.wr     = wr;
    g.addr   = addr;
    g.wd     = wd;
    g.wm     = pb ? wm : 4'h0;
    g.lat    = lat;
    g.rd     = rd;
    g.gap    = gap;
    r.port_b = pb;
    if (!pb) begin
      mdl_a = rd;
      r.rd  = rd;
    end else begin
      if (!wr) mdl_b = rd;
      r.rd = mdl_b;
    end
    last_b_m = pb;
    q_gnt.push_back(g);
    q_rsp.push_back(r);
  endtask

  // wait for all queued responses; release each port's request after its last resp
  task automatic drain();
    int   n;
    rsp_t r;
    n = 0;
    while (q_rsp.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (resp_a || resp_b) begin
        check_val("resp_excl", {63'd0, resp_a & resp_b}, 64'd0);
        r = q_rsp.pop_front();
        check_val("resp_port", {63'd0, resp_b}, {63'd0, r.port_b});
        if (r.port_b) check_val("rdata_b", {32'd0, rdata_b}, {32'd0, r.rd});
        else          check_val("rdata_a", {32'd0, rdata_a}, {32'd0, r.rd});
        if (resp_a && cnt_a > 0) begin
          cnt_a--;
          if (cnt_a == 0) read_a = 1'b0;
        end
        if (resp_b && cnt_b > 0) begin
          cnt_b--;
          if (cnt_b == 0) begin
            read_b = 1'b0;
            write  = 1'b0;
          end
        end
      end
    end
    if (q_rsp.size() != 0) begin
      check_val("drain_timeout", 64'(q_rsp.size()), 64'd0);
      q_rsp.delete();
      q_gnt.delete();
      read_a = 1'b0; read_b = 1'b0; write = 1'b0;
      cnt_a = 0; cnt_b = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_a(input logic [31:0] addr, input int lat, input logic [31:0] rd);
    read_a = 1'b1;
    address_a = addr;
    push_txn(1'b0, 1'b0, addr, 32'd0, 4'd0, lat, rd, 0);
    cnt_a = 1;
    drain();
  endtask

  task automatic do_b(input bit rdb, input bit wrb, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] wm, input int lat, input logic [31:0] rd);
    read_b = rdb;
    write = wrb;
    address_b = addr;
    wdata = wd;
    wmask = wm;
    push_txn(1'b1, wrb, addr, wd, wm, lat, rd, 0);
    cnt_b = 1;
    drain();
  endtask

  // both ports held until they have na / nb completions respectively
  task automatic contend(input int na, input int nb);
    int ra;
    int rb;
    bit pick_b;
    ra = na;
    rb = nb;
    read_a = 1'b1; address_a = 32'h0000_0A00;
    read_b = 1'b1; write = 1'b0; address_b = 32'h0000_0B00;
    wdata = 32'h0BAD_F00D; wmask = 4'hF;
    for (int i = 0; i < na + nb; i++) begin
      if (ra > 0 && rb > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_b = !last_b_m;
`else
        pick_b = 1'b1;
`endif
      end else begin
        pick_b = (rb > 0);
      end
      if (pick_b) rb--; else ra--;
      push_txn(pick_b, 1'b0, pick_b ? 32'h0000_0B00 : 32'h0000_0A00, 32'h0BAD_F00D, 4'hF,
               1 + (i % 2), 32'hC0DE_0000 + 32'(i), (i == 0) ? 0 : 3);
    end
    cnt_a = na;
    cnt_b = nb;
    drain();
  endtask

  // downstream memory model
  initial begin : responder
    gnt_t g;
    bit   abort;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        pmem_resp = 1'b1;
        pmem_rdata = 32'hBADB_AD00;
        @(posedge clk);
        #1 pmem_resp = 1'b0;
      end else if (rst_n && (pmem_read || pmem_write)) begin
        if (q_gnt.size() == 0) begin
          check_val("grant_unexpected", 64'd1, 64'd0);
          g = '{default: 0};
          g.lat = 1;
        end else begin
          g = q_gnt.pop_front();
          check_val("gnt_read", {63'd0, pmem_read}, {63'd0, !g.wr});
          check_val("gnt_write", {63'd0, pmem_write}, {63'd0, g.wr});
          check_val("gnt_addr", {32'd0, pmem_address}, {32'd0, g.addr});
          check_val("gnt_wmask", {60'd0, pmem_wmask}, {60'd0, g.wm});
          if (g.wr) check_val("gnt_wdata", {32'd0, pmem_wdata}, {32'd0, g.wd});
          if (g.gap > 0) check_val("gnt_gap", 64'(cyc - last_resp_cyc), 64'(g.gap));
        end
        abort = 1'b0;
        for (int i = 1; i < g.lat; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          pmem_resp = 1'b1;
          pmem_rdata = g.rd;
          last_resp_cyc = cyc;
          @(posedge clk);
          #1 pmem_resp = 1'b0;
          pmem_rdata = $urandom;
          @(negedge clk);
          check_val("strobe_drop", {62'd0, pmem_read, pmem_write}, 64'd0);
          check_val("resp_timing", {63'd0, g.port_b ? resp_b : resp_a}, 64'd1);
          @(negedge clk);
          check_val("resp_width", {63'd0, resp_a | resp_b}, 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit any_resp;
    // reset with a request already pending
    rst_n = 1'b0;
    read_a = 1'b1;
    address_a = 32'h0000_0040;
    repeat (3) @(negedge clk);
    check_val("rst_resp_a", {63'd0, resp_a}, 64'd0);
    check_val("rst_resp_b", {63'd0, resp_b}, 64'd0);
    check_val("rst_pmem_read", {63'd0, pmem_read}, 64'd0);
    check_val("rst_pmem_write", {63'd0, pmem_write}, 64'd0);
    check_val("rst_pmem_address", {32'd0, pmem_address}, 64'd0);
    check_val("rst_pmem_wdata", {32'd0, pmem_wdata}, 64'd0);
    check_val("rst_pmem_wmask", {60'd0, pmem_wmask}, 64'd0);
    check_val("rst_rdata_a", {32'd0, rdata_a}, 64'd0);
    check_val("rst_rdata_b", {32'd0, rdata_b}, 64'd0);
    push_txn(1'b0, 1'b0, 32'h0000_0040, 32'd0, 4'd0, 2, 32'h1111_1111, 0);
    cnt_a = 1;
    rst_n = 1'b1;
    drain();

    do_a(32'h0000_0100, 3, 32'hDEAD_BEEF);
    do_b(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
    do_b(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 2, 32'h5555_AAAA);
    // read_b and write together must behave as a write
    do_b(1'b1, 1'b1, 32'h0000_0380, 32'h8765_4321, 4'b1100, 1, 32'h7777_7777);

    contend(1, 1);
    contend(2, 2);

    // spurious downstream completion while idle
    spur_req++;
    any_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_a || resp_b) any_resp = 1'b1;
    end
    check_val("spur_resp", {63'd0, any_resp}, 64'd0);
    check_val("spur_rdata_a", {32'd0, rdata_a}, {32'd0, mdl_a});
    check_val("spur_rdata_b", {32'd0, rdata_b}, {32'd0, mdl_b});
    check_val("spur_strobe", {62'd0, pmem_read, pmem_write}, 64'd0);

    // requester withdraws mid-transaction: still completes and pulses resp
    read_a = 1'b1;
    address_a = 32'h0000_0600;
    push_txn(1'b0, 1'b0, 32'h0000_0600, 32'd0, 4'd0, 4, 32'h600D_600D, 0);
    cnt_a = 1;
    repeat (2) @(negedge clk);
    read_a = 1'b0;
    drain();

    // reset in the middle of a transaction
    read_a = 1'b1;
    address_a = 32'h0000_0700;
    push_txn(1'b0, 1'b0, 32'h0000_0700, 32'd0, 4'd0, 30, 32'h7000_0007, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_pmem_read", {63'd0, pmem_read}, 64'd0);
    check_val("mid_rst_pmem_address", {32'd0, pmem_address}, 64'd0);
    check_val("mid_rst_resp", {62'd0, resp_a, resp_b}, 64'd0);
    check_val("mid_rst_rdata_a", {32'd0, rdata_a}, 64'd0);
    check_val("mid_rst_rdata_b", {32'd0, rdata_b}, 64'd0);
    read_a = 1'b0;
    q_gnt.delete();
    q_rsp.delete();
    mdl_a = '0;
    mdl_b = '0;
    last_b_m = 1'b0;
    cnt_a = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    contend(1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
